timer_bank: RTL and testbench
=============================

TIMER_BANK -- requirements
Module: timer_bank

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the width of every channel counter and load value.
REQ-002 The block SHALL have parameter NCH, default 4, meaning the number of independent timer channels.
REQ-003 The block SHALL have parameter PW, default 16, meaning the width of the shared tick prescaler.

Interface
REQ-004 The block SHALL have clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have rst_i, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have tick_i, input, 1 bit: raw timebase tick enable, shared by all channels.
REQ-007 The block SHALL have prescale_i, input, PW bits: prescaler divide value; divide ratio is prescale_i+1.
REQ-008 The block SHALL have start_i, input, NCH bits: per-channel load-and-run strobe.
REQ-009 The block SHALL have stop_i, input, NCH bits: per-channel halt strobe.
REQ-010 The block SHALL have mode_i, input, NCH bits: per-channel mode, 0 = one-shot, 1 = auto-reload.
REQ-011 The block SHALL have load_i, input, NCH*WIDTH bits: per-channel load value; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-012 The block SHALL have count_o, output, NCH*WIDTH bits: per-channel current count, packed as load_i.
REQ-013 The block SHALL have busy_o, output, NCH bits: high while the channel is in RUN.
REQ-014 The block SHALL have zero_o, output, NCH bits: high while the channel count equals 0.
REQ-015 The block SHALL have done_o, output, NCH bits: one-cycle expiry pulse per channel.

Function
REQ-016 Prescaler SHALL keep a free-running PW-bit counter pre_cnt that advances only on cycles with tick_i=1.
REQ-017 On a cycle with tick_i=1, if pre_cnt >= prescale_i, the prescaler SHALL clear pre_cnt and assert internal tick_int combinationally in that cycle; otherwise it SHALL increment pre_cnt.
REQ-018 prescale_i=0 SHALL make tick_int equal to tick_i.
REQ-019 A prescale_i reduction below the current pre_cnt SHALL produce tick_int on the next tick_i.
REQ-020 start_i and stop_i SHALL NOT affect the prescaler.
REQ-021 Each channel SHALL hold the following registered state: count (WIDTH bits), shadow load value (WIDTH bits), mode (1 bit), and a state machine with states IDLE and RUN.
REQ-022 Per-channel priority SHALL be start_i > stop_i > tick_int.
REQ-023 start_i=1 SHALL capture load_i into the shadow, capture mode_i, and set count to load_i, all on the same edge.
REQ-024 If the load value is nonzero, start_i SHALL enter RUN.
REQ-025 If the load value is 0, start_i SHALL enter IDLE and pulse done_o on the same edge.
REQ-026 stop_i=1 without start_i SHALL enter IDLE and hold count, with no done_o pulse.
REQ-027 In RUN, on tick_int with count > 1, the channel SHALL set count to count-1.
REQ-028 In RUN, on tick_int with count == 1 in one-shot mode, the channel SHALL set count to 0, enter IDLE, and pulse done_o.
REQ-029 In RUN, on tick_int with count == 1 in auto-reload mode, the channel SHALL set count to the shadow value, remain in RUN, and pulse done_o; the period is therefore shadow ticks.
REQ-030 In IDLE, tick_int SHALL leave the channel unchanged.
REQ-031 load_i and mode_i changes while a channel is in RUN SHALL have no effect until the next start_i.
REQ-032 done_o SHALL be a registered output, high for exactly one cycle per expiry, and low on all other cycles.
REQ-033 busy_o and zero_o SHALL be decoded from registered state with no extra latency.
REQ-034 Channels SHALL be fully independent; simultaneous start_i, stop_i, or expiry on several channels SHALL be handled in the same cycle.
REQ-035 Count arithmetic SHALL be unsigned WIDTH-bit; count SHALL never decrement below 0 or wrap.
REQ-036 A load value of 2^WIDTH-1 SHALL be legal and SHALL count down normally.

Reset
REQ-037 rst_i=1 at a clock edge SHALL set all count and shadow registers to 0, mode to 0, all states to IDLE, and pre_cnt to 0.
REQ-038 During and after reset, done_o SHALL be 0, busy_o SHALL be 0, and zero_o SHALL be all ones.
REQ-039 rst_i SHALL override start_i, stop_i, and tick_i, including when asserted mid-count.

Verification
REQ-040 The bench SHALL cover this scenario: prescale=0, tick_i=1 every cycle, ch0 one-shot with load 3 -> count_o[0] reads 3,2,1,0; done_o[0] pulses once on the edge count becomes 0; busy_o[0] falls on that same edge.
REQ-041 The bench SHALL cover this scenario: prescale=2, tick_i continuous, ch1 auto-reload with load 2 -> done_o[1] pulses every 6 cycles; count_o[1] cycles 2,1,2,1; busy_o[1] stays 1.
REQ-042 The bench SHALL cover this scenario: start ch2 with load 0 -> done_o[2] pulses on the start edge; busy_o[2]=0; zero_o[2]=1.
REQ-043 The bench SHALL cover this scenario: ch0 running at count 5, stop_i[0] and tick coincide -> count stays 5, IDLE, no done_o; then start_i[0] and stop_i[0] together with load 7 -> count 7, RUN.
REQ-044 The bench SHALL cover this scenario: ch3 auto-reload with load 4, load_i changed to 9 mid-run -> reload stays 4 until the next start_i.
REQ-045 The bench SHALL cover this scenario: rst_i pulsed with all channels running -> next cycle all counts 0, busy_o=0, zero_o all ones, done_o=0.

Source files
------------

// File: rtl/timer_bank.sv
// timer_bank
//
// Bank of NCH independent down-counting timers that share one tick prescaler.
// The prescaler divides the raw tick_i enable by (prescale_i + 1) and produces
// an internal tick. Every channel counts down on that tick while it is running.
//
// Each channel has a registered count, a shadow copy of the value it was
// started with, and a latched mode bit. A channel can be one-shot (stops at 0)
// or auto-reload (reloads the shadow value on expiry and keeps running).
// Per-channel priority: start_i, then stop_i, then the internal tick.
//
// Ports
//   clk_i       : clock; all state changes on the rising edge
//   rst_i       : synchronous active-high reset
//   tick_i      : raw timebase tick enable, shared by all channels
//   prescale_i  : prescaler divide value, ratio = prescale_i + 1
//   start_i     : per-channel load-and-run strobe
//   stop_i      : per-channel halt strobe (count is held)
//   mode_i      : per-channel mode, 0 = one-shot, 1 = auto-reload
//   load_i      : per-channel load value, channel k at [k*WIDTH +: WIDTH]
//   count_o     : per-channel current count, packed like load_i
//   busy_o      : per-channel running flag
//   zero_o      : per-channel count-is-zero flag
//   done_o      : per-channel one-cycle expiry pulse (registered)

module timer_bank #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int PW    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tick_i,
    input  logic [PW-1:0]        prescale_i,
    input  logic [NCH-1:0]       start_i,
    input  logic [NCH-1:0]       stop_i,
    input  logic [NCH-1:0]       mode_i,
    input  logic [NCH*WIDTH-1:0] load_i,
    output logic [NCH*WIDTH-1:0] count_o,
    output logic [NCH-1:0]       busy_o,
    output logic [NCH-1:0]       zero_o,
    output logic [NCH-1:0]       done_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [PW-1:0]    PRE_ONE = PW'(1);

    logic [PW-1:0] pre_cnt;
    logic          tick_int;

    // The comparison is ">=" rather than "==" so that lowering prescale_i
    // below the current pre_cnt fires on the very next raw tick instead of
    // waiting for pre_cnt to wrap all the way around.
    assign tick_int = tick_i && (pre_cnt >= prescale_i);

    // Shared prescaler: only raw ticks advance it; channel strobes never
    // touch it, so all channels stay phase-aligned to the same timebase.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_cnt <= '0;
        end else if (tick_i) begin
            if (pre_cnt >= prescale_i) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PRE_ONE;
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [WIDTH-1:0] count;
        logic [WIDTH-1:0] shadow;
        logic             mode;
        logic             done;
        state_t           state;
        logic [WIDTH-1:0] load_val;

        assign load_val = load_i[k*WIDTH +: WIDTH];

        // Channel state machine. done is cleared every cycle and only set on
        // the edge where an expiry happens, which gives a one-cycle pulse.
        // A zero load expires immediately, so it never enters RUN.
        // The count==0 branch in RUN cannot normally be reached (RUN always
        // starts from a nonzero count and reloads a nonzero shadow); it just
        // parks the channel without wrapping the counter.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                count  <= '0;
                shadow <= '0;
                mode   <= 1'b0;
                done   <= 1'b0;
                state  <= IDLE;
            end else begin
                done <= 1'b0;
                if (start_i[k]) begin
                    shadow <= load_val;
                    mode   <= mode_i[k];
                    count  <= load_val;
                    if (load_val == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end else if (stop_i[k]) begin
                    state <= IDLE;
                end else if (tick_int && (state == RUN)) begin
                    if (count > CNT_ONE) begin
                        count <= count - CNT_ONE;
                    end else if (count == CNT_ONE) begin
                        done <= 1'b1;
                        if (mode) begin
                            count <= shadow;
                        end else begin
                            count <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            end
        end

        assign count_o[k*WIDTH +: WIDTH] = count;
        assign busy_o[k]                 = (state == RUN);
        assign zero_o[k]                 = (count == '0);
        assign done_o[k]                 = done;
    end

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank
//
// Directed bench for timer_bank. Each step drives the inputs, pushes the
// per-channel results expected after the next rising edge onto a scoreboard
// queue, then checkOutput waits for that edge and pops/compares every entry.

module tb_timer_bank;

    localparam int WIDTH = 32;
    localparam int NCH   = 4;
    localparam int PW    = 16;

    typedef struct {
        string            tag;
        int               ch;
        logic [WIDTH-1:0] cnt;
        logic             busy;
        logic             zero;
        logic             done;
    } exp_t;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 tick_i;
    logic [PW-1:0]        prescale_i;
    logic [NCH-1:0]       start_i;
    logic [NCH-1:0]       stop_i;
    logic [NCH-1:0]       mode_i;
    logic [NCH*WIDTH-1:0] load_i;
    logic [NCH*WIDTH-1:0] count_o;
    logic [NCH-1:0]       busy_o;
    logic [NCH-1:0]       zero_o;
    logic [NCH-1:0]       done_o;

    exp_t sb[$];
    int   tests;
    int   failures;

    // Expected ch1 counts for the auto-reload run at prescale 2, load 2.
    int ar_cnt[12] = '{2, 2, 1, 1, 1, 2, 2, 2, 1, 1, 1, 2};
    // Expected ch3 counts after the mid-run load_i change.
    int ar3_cnt[6] = '{4, 3, 2, 1, 4, 3};

    timer_bank #(
        .WIDTH(WIDTH),
        .NCH  (NCH),
        .PW   (PW)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .tick_i    (tick_i),
        .prescale_i(prescale_i),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .mode_i    (mode_i),
        .load_i    (load_i),
        .count_o   (count_o),
        .busy_o    (busy_o),
        .zero_o    (zero_o),
        .done_o    (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic setLoad(input int ch, input logic [WIDTH-1:0] v);
        load_i[ch*WIDTH +: WIDTH] = v;
    endtask

    task automatic applyStimulus(input logic r, input logic t,
                                 input logic [PW-1:0] p,
                                 input logic [NCH-1:0] st,
                                 input logic [NCH-1:0] sp,
                                 input logic [NCH-1:0] md);
        rst_i      = r;
        tick_i     = t;
        prescale_i = p;
        start_i    = st;
        stop_i     = sp;
        mode_i     = md;
    endtask

    task automatic pushExpect(input string tag, input int ch,
                              input logic [WIDTH-1:0] cnt,
                              input logic busy, input logic done);
        exp_t e;
        e.tag  = tag;
        e.ch   = ch;
        e.cnt  = cnt;
        e.busy = busy;
        e.zero = (cnt == '0);
        e.done = done;
        sb.push_back(e);
    endtask

    task automatic pushAll(input string tag, input logic [WIDTH-1:0] cnt,
                           input logic busy, input logic done);
        for (int c = 0; c < NCH; c++) begin
            pushExpect(tag, c, cnt, busy, done);
        end
    endtask

    // Wait for the next rising edge, settle, then drain the scoreboard.
    task automatic checkOutput();
        exp_t             e;
        logic [WIDTH+2:0] obs;
        logic [WIDTH+2:0] exv;
        @(posedge clk_i);
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = {count_o[e.ch*WIDTH +: WIDTH], busy_o[e.ch], zero_o[e.ch], done_o[e.ch]};
            exv = {e.cnt, e.busy, e.zero, e.done};
            tests++;
            assert (obs === exv) else begin
                failures++;
                $display("[TB] FAIL %s ch%0d: observed cnt=%0h busy=%b zero=%b done=%b, expected cnt=%0h busy=%b zero=%b done=%b",
                         e.tag, e.ch, obs[WIDTH+2:3], obs[2], obs[1], obs[0],
                         e.cnt, e.busy, e.zero, e.done);
                $error("[TB] check %s ch%0d did not match", e.tag, e.ch);
            end
        end
    endtask

    initial begin
        tests    = 0;
        failures = 0;
        load_i   = '0;

        // Reset must win over start and tick, and hold while asserted.
        for (int c = 0; c < NCH; c++) setLoad(c, 32'd5);
        applyStimulus(1'b1, 1'b1, 16'd0, 4'hF, 4'h0, 4'hF);
        pushAll("reset_assert", 32'd0, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(1'b1, 1'b1, 16'd0, 4'hF, 4'h0, 4'h0);
        pushAll("reset_hold", 32'd0, 1'b0, 1'b0);
        checkOutput();

        // One-shot ch0, load 3, prescale 0, tick every cycle.
        setLoad(0, 32'd3);
        applyStimulus(1'b0, 1'b1, 16'd0, 4'b0001, 4'h0, 4'h0);
        pushExpect("os_load", 0, 32'd3, 1'b1, 1'b0);
        checkOutput();
        applyStimulus(1'b0, 1'b1, 16'd0, 4'h0, 4'h0, 4'h0);
        pushExpect("os_cnt2", 0, 32'd2, 1'b1, 1'b0);
        checkOutput();
        pushExpect("os_cnt1", 0, 32'd1, 1'b1, 1'b0);
        checkOutput();
        pushExpect("os_expire", 0, 32'd0, 1'b0, 1'b1);
        checkOutput();
        pushExpect("os_done_clear", 0, 32'd0, 1'b0, 1'b0);
        checkOutput();

        // Auto-reload ch1, load 2, prescale 2: done every 6 cycles.
        setLoad(1, 32'd2);
        applyStimulus(1'b0, 1'b1, 16'd2, 4'b0010, 4'h0, 4'b0010);
        pushExpect("ar_load", 1, 32'(ar_cnt[0]), 1'b1, 1'b0);
        checkOutput();
        for (int i = 1; i < 12; i++) begin
            applyStimulus(1'b0, 1'b1, 16'd2, 4'h0, 4'h0, 4'h0);
            pushExpect("ar_run", 1, 32'(ar_cnt[i]), 1'b1, (i == 5 || i == 11));
            if (i == 6) pushExpect("idle_tick", 0, 32'd0, 1'b0, 1'b0);
            checkOutput();
        end
        applyStimulus(1'b0, 1'b1, 16'd2, 4'h0, 4'b0010, 4'h0);
        pushExpect("ar_stop", 1, 32'd2, 1'b0, 1'b0);
        checkOutput();

        // Zero load on ch2 expires on the start edge.
        setLoad(2, 32'd0);
        applyStimulus(1'b0, 1'b0, 16'd2, 4'b0100, 4'h0, 4'h0);
        pushExpect("zero_load", 2, 32'd0, 1'b0, 1'b1);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 16'd2, 4'h0, 4'h0, 4'h0);
        pushExpect("zero_clear", 2, 32'd0, 1'b0, 1'b0);
        checkOutput();

        // Stop beats tick; start beats stop.
        setLoad(0, 32'd5);
        applyStimulus(1'b0, 1'b0, 16'd0, 4'b0001, 4'h0, 4'h0);
        pushExpect("run5", 0, 32'd5, 1'b1, 1'b0);
        checkOutput();
        applyStimulus(1'b0, 1'b1, 16'd0, 4'h0, 4'b0001, 4'h0);
        pushExpect("stop_tick", 0, 32'd5, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(1'b0, 1'b1, 16'd0, 4'h0, 4'h0, 4'h0);
        pushExpect("idle_hold", 0, 32'd5, 1'b0, 1'b0);
        checkOutput();
        setLoad(0, 32'd7);
        applyStimulus(1'b0, 1'b1, 16'd0, 4'b0001, 4'b0001, 4'h0);
        pushExpect("start_over_stop", 0, 32'd7, 1'b1, 1'b0);
        checkOutput();
        applyStimulus(1'b0, 1'b1, 16'd0, 4'h0, 4'h0, 4'h0);
        pushExpect("restart_cnt", 0, 32'd6, 1'b1, 1'b0);
        checkOutput();

        // Auto-reload ch3 load 4; load_i/mode_i changes mid-run are ignored.
        setLoad(3, 32'd4);
        applyStimulus(1'b0, 1'b1, 16'd0, 4'b1000, 4'h0, 4'b1000);
        pushExpect("ar3_load", 3, 32'(ar3_cnt[0]), 1'b1, 1'b0);
        checkOutput();
        setLoad(3, 32'd9);
        for (int i = 1; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, 16'd0, 4'h0, 4'h0, 4'h0);
            pushExpect("ar3_run", 3, 32'(ar3_cnt[i]), 1'b1, (i == 4));
            if (i == 5) pushExpect("os_expire2", 0, 32'd0, 1'b0, 1'b1);
            checkOutput();
        end
        applyStimulus(1'b0, 1'b1, 16'd0, 4'b1000, 4'h0, 4'b1000);
        pushExpect("ar3_restart", 3, 32'd9, 1'b1, 1'b0);
        checkOutput();
        applyStimulus(1'b0, 1'b1, 16'd0, 4'h0, 4'h0, 4'h0);
        pushExpect("ar3_cnt8", 3, 32'd8, 1'b1, 1'b0);
        checkOutput();

        // Prescaler: climb to pre_cnt 4 at prescale 5, then drop prescale to 1.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 16'd5, 4'h0, 4'h0, 4'h0);
            pushExpect("pre_hold", 3, 32'd8, 1'b1, 1'b0);
            checkOutput();
        end
        applyStimulus(1'b0, 1'b1, 16'd1, 4'h0, 4'h0, 4'h0);
        pushExpect("pre_reduce", 3, 32'd7, 1'b1, 1'b0);
        checkOutput();
        pushExpect("pre_wait", 3, 32'd7, 1'b1, 1'b0);
        checkOutput();
        pushExpect("pre_tick", 3, 32'd6, 1'b1, 1'b0);
        checkOutput();

        // Maximum load value counts down normally.
        setLoad(2, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b0, 16'd0, 4'b0100, 4'h0, 4'h0);
        pushExpect("max_load", 2, 32'hFFFF_FFFF, 1'b1, 1'b0);
        checkOutput();
        applyStimulus(1'b0, 1'b1, 16'd0, 4'h0, 4'h0, 4'h0);
        pushExpect("max_dec", 2, 32'hFFFF_FFFE, 1'b1, 1'b0);
        checkOutput();

        // Reset with every channel running.
        for (int c = 0; c < NCH; c++) setLoad(c, 32'd10);
        applyStimulus(1'b0, 1'b0, 16'd0, 4'hF, 4'h0, 4'b1010);
        pushAll("all_run", 32'd10, 1'b1, 1'b0);
        checkOutput();
        applyStimulus(1'b1, 1'b1, 16'd0, 4'h0, 4'h0, 4'h0);
        pushAll("mid_reset", 32'd0, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(1'b0, 1'b1, 16'd0, 4'h0, 4'h0, 4'h0);
        pushAll("post_reset", 32'd0, 1'b0, 1'b0);
        checkOutput();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
